// File: rtl/mcdf_pkt_scheduler.sv
// Packet-level round-robin scheduler between four channel FIFOs and the MCDF formatter.
// A whole packet is moved from one channel before the arbitration pointer advances.
module mcdf_pkt_scheduler #(
    parameter int DATA_W  = 32,
    parameter int AVAIL_W = 6,
    parameter int GAP_CYC = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [3:0]           ch_en_i,
    input  logic [11:0]          ch_len_i,
    input  logic [4*AVAIL_W-1:0] ch_avail_i,
    input  logic [4*DATA_W-1:0]  ch_data_i,
    output logic [3:0]           ch_pop_o,
    output logic                 fmt_req_o,
    input  logic                 fmt_grant_i,
    output logic [1:0]           fmt_id_o,
    output logic [5:0]           fmt_len_o,
    output logic                 fmt_valid_o,
    input  logic                 fmt_ready_i,
    output logic [DATA_W-1:0]    fmt_data_o,
    output logic                 fmt_start_o,
    output logic                 fmt_end_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t      state;
    logic [1:0]  last;
    logic [5:0]  cnt;
    logic [15:0] gap_cnt;
    logic [5:0]  dec_len [4];
    logic [3:0]  elig;
    logic        any_elig;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;
    logic        beat_ok;

    function automatic logic [5:0] decode_len(input logic [2:0] code);
        case (code)
            3'd0:    decode_len = 6'd4;
            3'd1:    decode_len = 6'd8;
            3'd2:    decode_len = 6'd16;
            default: decode_len = 6'd32;
        endcase
    endfunction

    // A channel is eligible only if its FIFO already holds the whole packet.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            dec_len[n] = decode_len(ch_len_i[3*n +: 3]);
            elig[n]    = ch_en_i[n] &&
                         (32'(ch_avail_i[n*AVAIL_W +: AVAIL_W]) >= 32'(dec_len[n]));
        end
        any_elig = |elig;
    end

    // Offsets 1..4 from the last winner; offset 4 wraps back to the last winner itself.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign busy_o      = (state != IDLE);
    assign fmt_valid_o = (state == SEND);
    assign beat_ok     = fmt_valid_o && fmt_ready_i;
    assign fmt_start_o = fmt_valid_o && (cnt == 6'd0);
    assign fmt_end_o   = fmt_valid_o && (cnt == fmt_len_o - 6'd1);
    assign fmt_data_o  = fmt_valid_o ? ch_data_i[int'(fmt_id_o)*DATA_W +: DATA_W] : '0;

    always_comb begin
        ch_pop_o = 4'b0000;
        if (beat_ok) begin
            ch_pop_o[fmt_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            last      <= 2'd3;
            cnt       <= 6'd0;
            gap_cnt   <= 16'd0;
            fmt_req_o <= 1'b0;
            fmt_id_o  <= 2'd0;
            fmt_len_o <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        fmt_id_o  <= winner;
                        fmt_len_o <= dec_len[winner];
                        fmt_req_o <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        fmt_req_o <= 1'b0;
                        cnt       <= 6'd0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (beat_ok) begin
                        if (cnt == fmt_len_o - 6'd1) begin
                            last    <= fmt_id_o;
                            cnt     <= 6'd0;
                            gap_cnt <= 16'd0;
                            state   <= (GAP_CYC > 0) ? GAP : IDLE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'(GAP_CYC - 1)) begin
                        gap_cnt <= 16'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcdf_pkt_scheduler.sv
// Directed self-checking bench for mcdf_pkt_scheduler: reset, arbitration order,
// backpressure, eligibility thresholds, mid-packet enable drop and mid-packet reset.
module tb_mcdf_pkt_scheduler;

    logic         clk;
    logic         rst_n;
    logic [3:0]   ch_en;
    logic [11:0]  ch_len;
    logic [23:0]  ch_avail;
    logic [127:0] ch_data;
    logic [3:0]   ch_pop;
    logic         fmt_req;
    logic         fmt_grant;
    logic [1:0]   fmt_id;
    logic [5:0]   fmt_len;
    logic         fmt_valid;
    logic         fmt_ready;
    logic [31:0]  fmt_data;
    logic         fmt_start;
    logic         fmt_end;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mcdf_pkt_scheduler #(.DATA_W(32), .AVAIL_W(6), .GAP_CYC(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ch_en_i(ch_en), .ch_len_i(ch_len),
        .ch_avail_i(ch_avail), .ch_data_i(ch_data), .ch_pop_o(ch_pop),
        .fmt_req_o(fmt_req), .fmt_grant_i(fmt_grant), .fmt_id_o(fmt_id),
        .fmt_len_o(fmt_len), .fmt_valid_o(fmt_valid), .fmt_ready_i(fmt_ready),
        .fmt_data_o(fmt_data), .fmt_start_o(fmt_start), .fmt_end_o(fmt_end),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are checked 1 ns later.
    task automatic apply_reset();
        rst_n = 1'b0; ch_en = '0; ch_len = '0; ch_avail = '0; ch_data = '0;
        fmt_grant = 1'b0; fmt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = 4'hF; ch_len = '0; ch_avail = {4{6'd32}};
        ch_data = {4{32'hDEAD_BEEF}}; fmt_grant = 1'b1; fmt_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, fmt_req, fmt_valid, fmt_start, fmt_end} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, fmt_req, fmt_valid, fmt_start, fmt_end});
        end
        checks++;
        if ({ch_pop, fmt_id, fmt_len, fmt_data} !== 44'h0) begin
            errors++; $display("[TB] FAIL reset_data: pop=%b id=%0d len=%0d data=%h expected all 0", ch_pop, fmt_id, fmt_len, fmt_data);
        end
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0001; ch_len = 12'h000; ch_avail = {6'd0, 6'd0, 6'd0, 6'd4};
        #1;
        checks++;
        if (fmt_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_early: got %b expected 0", fmt_req); end
        @(negedge clk);
        fmt_grant = 1'b1; fmt_ready = 1'b1;
        #1;
        checks++;
        if ({fmt_req, busy, fmt_id, fmt_len} !== {1'b1, 1'b1, 2'd0, 6'd4}) begin
            errors++; $display("[TB] FAIL single_req: req=%b busy=%b id=%0d len=%0d expected 1 1 0 4", fmt_req, busy, fmt_id, fmt_len);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fmt_grant = 1'b0;
            ch_data = {96'h0, 32'h1000_0000 + 32'(k)};
            #1;
            checks++;
            if ({fmt_valid, fmt_req, ch_pop, fmt_start, fmt_end} !== {1'b1, 1'b0, 4'b0001, k == 0, k == 3}) begin
                errors++; $display("[TB] FAIL single_beat%0d: valid=%b req=%b pop=%b start=%b end=%b", k, fmt_valid, fmt_req, ch_pop, fmt_start, fmt_end);
            end
            checks++;
            if (fmt_data !== 32'h1000_0000 + 32'(k)) begin
                errors++; $display("[TB] FAIL single_data%0d: got %h expected %h", k, fmt_data, 32'h1000_0000 + 32'(k));
            end
        end
        @(negedge clk);
        ch_en = 4'b0000;
        #1;
        checks++;
        if ({fmt_valid, busy, ch_pop} !== {1'b0, 1'b1, 4'b0000}) begin
            errors++; $display("[TB] FAIL single_gap: valid=%b busy=%b pop=%b expected 0 1 0000", fmt_valid, busy, ch_pop);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy, fmt_req} !== 2'b00) begin
            errors++; $display("[TB] FAIL single_idle: busy=%b req=%b expected 0 0", busy, fmt_req);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        int         wait_cyc;
        apply_reset();
        @(negedge clk);
        ch_en = 4'b1111; ch_len = 12'h000; ch_avail = {4{6'd32}};
        ch_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        fmt_grant = 1'b1; fmt_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            exp_id = 2'(p % 4);
            wait_cyc = 0;
            do begin
                @(negedge clk);
                #1;
                wait_cyc++;
            end while (!fmt_start && wait_cyc < 10);
            checks++;
            if (!fmt_start) begin
                errors++; $display("[TB] FAIL rr_start_timeout: pkt %0d got no start in %0d cycles", p, wait_cyc);
                return;
            end
            if (p > 0) begin
                checks++;
                if (wait_cyc != 4) begin
                    errors++; $display("[TB] FAIL rr_turnaround: pkt %0d start after %0d cycles expected 4", p, wait_cyc);
                end
            end
            checks++;
            if ({fmt_id, fmt_data} !== {exp_id, 32'hA000_0000 + 32'(exp_id)}) begin
                errors++; $display("[TB] FAIL rr_order: pkt %0d id=%0d data=%h expected id %0d", p, fmt_id, fmt_data, exp_id);
            end
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                checks++;
                if ({ch_pop, fmt_valid, fmt_end} !== {4'b0001 << exp_id, 1'b1, k == 3}) begin
                    errors++; $display("[TB] FAIL rr_beat: pkt %0d beat %0d pop=%b valid=%b end=%b", p, k, ch_pop, fmt_valid, fmt_end);
                end
            end
        end
        @(negedge clk);
        ch_en = 4'b0000; fmt_grant = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [5:0] pattern;
        int         acc;
        pattern = 6'b110101;
        acc = 0;
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0001; ch_len = 12'h000; ch_avail = {6'd0, 6'd0, 6'd0, 6'd4};
        @(negedge clk);
        fmt_grant = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fmt_grant = 1'b0;
            fmt_ready = pattern[c];
            ch_data = {96'h0, 32'h5500_0000 + 32'(acc)};
            #1;
            checks++;
            if ({fmt_valid, ch_pop, fmt_start, fmt_end} !== {1'b1, pattern[c] ? 4'b0001 : 4'b0000, acc == 0, acc == 3}) begin
                errors++; $display("[TB] FAIL bp_cycle%0d: valid=%b pop=%b start=%b end=%b acc=%0d", c, fmt_valid, ch_pop, fmt_start, fmt_end, acc);
            end
            checks++;
            if (fmt_data !== 32'h5500_0000 + 32'(acc)) begin
                errors++; $display("[TB] FAIL bp_data%0d: got %h expected %h", c, fmt_data, 32'h5500_0000 + 32'(acc));
            end
            if (pattern[c]) acc++;
        end
        @(negedge clk);
        ch_en = 4'b0000;
        #1;
        checks++;
        if ({fmt_valid, busy} !== 2'b01) begin
            errors++; $display("[TB] FAIL bp_done: valid=%b busy=%b expected 0 1", fmt_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_threshold();
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0010; ch_len = 12'h008; ch_avail = {6'd0, 6'd0, 6'd7, 6'd0};
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({fmt_req, busy} !== 2'b00) begin
            errors++; $display("[TB] FAIL thr_below: req=%b busy=%b expected 0 0", fmt_req, busy);
        end
        ch_avail = {6'd0, 6'd0, 6'd8, 6'd0};
        @(negedge clk);
        #1;
        checks++;
        if ({fmt_req, fmt_id, fmt_len} !== {1'b1, 2'd1, 6'd8}) begin
            errors++; $display("[TB] FAIL thr_at: req=%b id=%0d len=%0d expected 1 1 8", fmt_req, fmt_id, fmt_len);
        end
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0010; ch_len = 12'h030; ch_avail = {6'd0, 6'd0, 6'd32, 6'd0};
        @(negedge clk);
        #1;
        checks++;
        if ({fmt_req, fmt_id, fmt_len} !== {1'b1, 2'd1, 6'd32}) begin
            errors++; $display("[TB] FAIL thr_code6: req=%b id=%0d len=%0d expected 1 1 32", fmt_req, fmt_id, fmt_len);
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0100; ch_len = 12'h000; ch_avail = {6'd0, 6'd32, 6'd0, 6'd0};
        @(negedge clk);
        fmt_grant = 1'b1; fmt_ready = 1'b1;
        #1;
        checks++;
        if ({fmt_req, fmt_id} !== {1'b1, 2'd2}) begin
            errors++; $display("[TB] FAIL drop_req: req=%b id=%0d expected 1 2", fmt_req, fmt_id);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fmt_grant = 1'b0;
            if (k == 2) begin
                ch_en = 4'b1001; ch_avail = {6'd32, 6'd32, 6'd0, 6'd32};
            end
            #1;
            checks++;
            if ({ch_pop, fmt_end} !== {4'b0100, k == 3}) begin
                errors++; $display("[TB] FAIL drop_beat%0d: pop=%b end=%b expected 0100 %b", k, ch_pop, fmt_end, k == 3);
            end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({fmt_req, fmt_id} !== {1'b1, 2'd3}) begin
            errors++; $display("[TB] FAIL drop_next: req=%b id=%0d expected 1 3", fmt_req, fmt_id);
        end
    endtask

    task automatic test_reset_mid_send();
        apply_reset();
        @(negedge clk);
        ch_en = 4'b0001; ch_len = 12'h000; ch_avail = {6'd0, 6'd0, 6'd0, 6'd32};
        ch_data = {96'h0, 32'h7777_0000};
        @(negedge clk);
        fmt_grant = 1'b1; fmt_ready = 1'b1;
        repeat (2) @(negedge clk);
        fmt_grant = 1'b0;
        #1;
        checks++;
        if (fmt_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_send: valid=%b expected 1", fmt_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, fmt_req, fmt_valid, fmt_start, fmt_end, ch_pop, fmt_id, fmt_len, fmt_data} !== 49'h0) begin
            errors++; $display("[TB] FAIL rst_mid_send: busy=%b req=%b valid=%b pop=%b id=%0d len=%0d data=%h expected all 0", busy, fmt_req, fmt_valid, ch_pop, fmt_id, fmt_len, fmt_data);
        end
        ch_en = 4'b1001; ch_avail = {6'd32, 6'd0, 6'd0, 6'd32}; fmt_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({fmt_req, fmt_id} !== {1'b1, 2'd0}) begin
            errors++; $display("[TB] FAIL rst_rr_restart: req=%b id=%0d expected 1 0", fmt_req, fmt_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_threshold();
        test_enable_drop();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcdf_pkt_scheduler.md
Name: mcdf_pkt_scheduler

Overview:
- Packet-level scheduler between four channel slave FIFOs and the MCDF formatter.
- Chooses one eligible channel by round-robin and requests a packet slot from the formatter.
- Once the slot is granted, moves exactly one packet of words from that channel to the formatter, with per-beat valid/ready backpressure.
- The round-robin pointer advances only at packet boundaries, so packets from different channels never interleave.

Parameters:
DATA_W, 32, width of channel and formatter data words
AVAIL_W, 6, width of each channel FIFO level count (level range 0..32)
GAP_CYC, 1, idle cycles inserted after each packet (0 = none)

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
ch_en_i  input  4  per-channel enable
ch_len_i  input  12  packed 4x3 packet-length code, channel n at [3n+2:3n]
ch_avail_i  input  4*AVAIL_W  packed per-channel FIFO level
ch_data_i  input  4*DATA_W  packed per-channel FIFO head word
ch_pop_o  output  4  one-hot FIFO pop strobe
fmt_req_o  output  1  packet slot request to formatter
fmt_grant_i  input  1  formatter grants the requested slot
fmt_id_o  output  2  channel id of the current packet
fmt_len_o  output  6  packet length in words
fmt_valid_o  output  1  data beat valid
fmt_ready_i  input  1  formatter accepts beat
fmt_data_o  output  DATA_W  beat data
fmt_start_o  output  1  first beat of packet
fmt_end_o  output  1  last beat of packet
busy_o  output  1  scheduler not in IDLE

Behaviour:
- Reset (asynchronous, active-low, immediate): all outputs 0; FSM = IDLE; RR last-winner pointer = 3, so ch0 has highest priority first; beat and gap counters = 0.
- Length decode: code 0→4, 1→8, 2→16, 3→32, 4..7→32 words.
- Eligibility: channel n is eligible when ch_en_i[n]=1 and ch_avail_i[n] >= decoded length[n]. This guarantees no FIFO underflow.
- Round-robin: search starts at (last+1) mod 4 and proceeds ascending with wrap; the first eligible channel wins.
- FSM states: IDLE, REQ, SEND, GAP.
- IDLE:
  - If any channel is eligible, register winner id and decoded length into fmt_id_o/fmt_len_o and go to REQ.
  - fmt_req_o rises one cycle after eligibility is sampled.
- REQ:
  - fmt_req_o=1; fmt_id_o and fmt_len_o held stable.
  - Wait for fmt_grant_i. On grant go to SEND; fmt_req_o falls the next cycle.
  - Eligibility changes while in REQ are ignored; the request is never withdrawn.
- SEND:
  - fmt_valid_o=1.
  - fmt_data_o = ch_data_i[id], combinational mux.
  - ch_pop_o[id] = fmt_ready_i, combinational; other pop bits 0.
  - A beat is accepted when valid&ready; the beat counter increments per accepted beat.
  - fmt_start_o = valid & (cnt==0); fmt_end_o = valid & (cnt==len-1).
  - On the accepted end beat: pointer = id, counter = 0. Next state is GAP if GAP_CYC>0, else IDLE.
- GAP: fmt_valid_o=0; hold for GAP_CYC cycles, then IDLE.
- busy_o = (state != IDLE).
- Minimum turnaround per packet is len + GAP_CYC + 2 cycles, given an immediate grant and ready held high.
- ch_en_i deassert or ch_len_i change mid-packet: no effect; the packet completes with its latched id/len.
- fmt_ready_i low: no pop, data/start/end held, counter frozen.
- fmt_grant_i outside REQ: ignored.

Test Plan:
1. Reset release; ch0 en, len code 0, avail=4, others off → fmt_req_o=1 one cycle later with id=0, len=4. Grant, ready=1 → 4 beats, ch_pop_o=0001 for 4 cycles, start on beat1, end on beat4. One GAP cycle, then busy_o=0.
2. All channels enabled, len code 0, avail=32, grant/ready tied 1 → packet id order 0,1,2,3,0,1; no interleaving within a packet.
3. Single packet len 4 with ready pattern 1,0,1,0,1,1 → exactly 4 pops, data stable while ready=0, fmt_end_o on the 4th accepted beat.
4. ch1 only, len code 1, avail=7 → fmt_req_o stays 0; avail→8 → request with len=8. Code 6 with avail=32 → len=32.
5. ch2 in SEND, deassert ch_en_i[2] after beat 2 → all beats complete. Pointer=2 afterwards, so ch3 wins the next arbitration over ch0.
6. Assert rst_n_i low mid-SEND → all outputs 0 immediately. After release with ch0 and ch3 eligible → ch0 granted first.
